// File: rtl/mpe_result_collector.sv
// ---------------------------------------------------------------------------
// mpe_result_collector
//
// Downstream stage of the MPE core. Each MPU lane delivers result words into
// a one-deep lane register. The collector picks pending lanes round-robin and
// serialises their words into the global output buffer write port. A write
// address advances from a programmed base. The job finishes once the
// programmed number of words has been accepted by the buffer.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        begin a job (only looked at while idle)
//   i_base_addr    first write address, latched on an accepted start
//   i_num_results  number of words to write, latched on an accepted start
//   i_mpu_data     lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
//   i_mpu_valid    per-lane strobe, one word per high cycle
//   o_wr_en        write request to the global buffer
//   o_wr_addr      write address
//   o_wr_data      write data
//   i_wr_ready     buffer accepts; a transfer is o_wr_en & i_wr_ready
//   o_busy         high while collecting
//   o_done         one-cycle pulse at the end of a job
//   o_overflow     sticky lane overrun flag, cleared by reset or a new job
// ---------------------------------------------------------------------------
module mpe_result_collector #(
    parameter int NUM_MPUS   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [ADDR_WIDTH-1:0]          i_base_addr,
    input  logic [ADDR_WIDTH:0]            i_num_results,
    input  logic [NUM_MPUS*DATA_WIDTH-1:0] i_mpu_data,
    input  logic [NUM_MPUS-1:0]            i_mpu_valid,
    output logic                           o_wr_en,
    output logic [ADDR_WIDTH-1:0]          o_wr_addr,
    output logic [DATA_WIDTH-1:0]          o_wr_data,
    input  logic                           i_wr_ready,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_overflow
);

    localparam int PTR_W = (NUM_MPUS > 1) ? $clog2(NUM_MPUS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_laneData [NUM_MPUS];
    logic [NUM_MPUS-1:0]     r_pending;
    logic [PTR_W-1:0]        r_ptr;
    logic [ADDR_WIDTH-1:0]   r_nextAddr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     r_numResults;
    logic                    r_wrEn;
    logic [ADDR_WIDTH-1:0]   r_wrAddr;
    logic [DATA_WIDTH-1:0]   r_wrData;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;

    logic                    w_xfer;
    logic                    w_slotFree;
    logic                    w_needMore;
    logic [ADDR_WIDTH:0]     w_remaining;
    logic                    w_found;
    logic [PTR_W-1:0]        w_lane;
    logic [PTR_W-1:0]        w_cand;
    logic [PTR_W-1:0]        w_nextPtr;
    logic                    w_grant;
    logic [NUM_MPUS-1:0]     w_drain;

    // A new grant may issue when the output register is empty or is being
    // emptied this very cycle, and the words already accepted plus the one
    // in flight have not yet reached the job size. r_count never exceeds
    // r_numResults, so the subtraction cannot underflow.
    always_comb begin
        w_xfer      = r_wrEn & i_wr_ready;
        w_slotFree  = ~r_wrEn | i_wr_ready;
        w_remaining = r_numResults - r_count;
        w_needMore  = (w_remaining > {{ADDR_WIDTH{1'b0}}, r_wrEn});
    end

    // Round-robin search: first pending lane at or after the pointer,
    // wrapping around the lane count.
    always_comb begin
        w_found = 1'b0;
        w_lane  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_MPUS; i++) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % NUM_MPUS);
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_lane  = w_cand;
            end
        end
    end

    // Grant decision plus the one-hot drain mask used by the capture logic
    // to tell an overrun apart from a same-cycle drain and refill.
    always_comb begin
        w_grant   = (r_state == ST_COLLECT) && w_slotFree && w_needMore && w_found;
        w_nextPtr = (int'(w_lane) == NUM_MPUS - 1) ? '0 : w_lane + PTR_W'(1);
        w_drain   = '0;
        if (w_grant) begin
            w_drain[w_lane] = 1'b1;
        end
    end

    // Main controller: job state, lane capture, output register and
    // handshake bookkeeping. All outputs come straight from these registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_ptr        <= '0;
            r_nextAddr   <= '0;
            r_count      <= '0;
            r_numResults <= '0;
            r_wrEn       <= 1'b0;
            r_wrAddr     <= '0;
            r_wrData     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            for (int k = 0; k < NUM_MPUS; k++) begin
                r_laneData[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_COLLECT;
                        r_nextAddr   <= i_base_addr;
                        r_numResults <= i_num_results;
                        r_count      <= '0;
                        r_overflow   <= 1'b0;
                        r_pending    <= '0;
                        r_ptr        <= '0;
                        r_busy       <= 1'b1;
                    end
                end

                ST_COLLECT: begin
                    if (w_xfer) begin
                        r_count <= r_count + (ADDR_WIDTH+1)'(1);
                    end

                    // A grant in the same cycle as a transfer keeps wr_en
                    // high so a ready buffer sees one word per cycle.
                    if (w_grant) begin
                        r_wrEn     <= 1'b1;
                        r_wrAddr   <= r_nextAddr;
                        r_wrData   <= r_laneData[w_lane];
                        r_nextAddr <= r_nextAddr + ADDR_WIDTH'(1);
                        r_ptr      <= w_nextPtr;
                    end else if (w_xfer) begin
                        r_wrEn <= 1'b0;
                    end

                    // A strobe on a lane that still holds an undrained word
                    // drops the new word and keeps the old one.
                    for (int k = 0; k < NUM_MPUS; k++) begin
                        if (i_mpu_valid[k]) begin
                            if (r_pending[k] && !w_drain[k]) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_laneData[k] <= i_mpu_data[k*DATA_WIDTH +: DATA_WIDTH];
                                r_pending[k]  <= 1'b1;
                            end
                        end else if (w_drain[k]) begin
                            r_pending[k] <= 1'b0;
                        end
                    end

                    if ((r_count == r_numResults) && !r_wrEn) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_pending <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr_en    = r_wrEn;
    assign o_wr_addr  = r_wrAddr;
    assign o_wr_data  = r_wrData;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_mpe_result_collector.sv
// ---------------------------------------------------------------------------
// tb_mpe_result_collector
//
// Self-checking bench for mpe_result_collector. Directed scenarios cover
// reset, a four-lane burst, address wrap, backpressure, lane overrun and a
// mid-job reset followed by an empty job. A randomized run compares the DUT
// cycle by cycle against a behavioural model built from lane slots, a
// pending-request record and word counters.
// ---------------------------------------------------------------------------
module tb_mpe_result_collector;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [9:0]  i_base_addr;
    logic [10:0] i_num_results;
    logic [31:0] i_mpu_data;
    logic [3:0]  i_mpu_valid;
    logic        o_wr_en;
    logic [9:0]  o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        i_wr_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int checkCount = 0;
    int errorCount = 0;

    mpe_result_collector #(
        .NUM_MPUS   (4),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (10)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_num_results (i_num_results),
        .i_mpu_data    (i_mpu_data),
        .i_mpu_valid   (i_mpu_valid),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .i_wr_ready    (i_wr_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow)
    );

    // Free-running 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Behavioural model state for the randomized run.
    typedef enum int {P_IDLE, P_COLLECT, P_DONE} phase_t;
    phase_t      mPhase;
    logic [7:0]  mLane [4];
    bit          mFull [4];
    int          mPtr;
    bit          mReq;
    logic [9:0]  mReqAddr;
    logic [7:0]  mReqData;
    int          mNextAddr;
    int          mWritten;
    int          mTarget;
    bit          mBusy;
    bit          mDone;
    bit          mOvf;
    int          mJobs;

    task automatic modelReset();
        mPhase    = P_IDLE;
        mPtr      = 0;
        mReq      = 1'b0;
        mReqAddr  = '0;
        mReqData  = '0;
        mNextAddr = 0;
        mWritten  = 0;
        mTarget   = 0;
        mBusy     = 1'b0;
        mDone     = 1'b0;
        mOvf      = 1'b0;
        mJobs     = 0;
        for (int k = 0; k < 4; k++) begin
            mLane[k] = '0;
            mFull[k] = 1'b0;
        end
    endtask

    // One clock edge of the model, given the inputs the DUT saw at that edge.
    task automatic modelStep(input bit st, input logic [9:0] base, input logic [10:0] num,
                             input logic [3:0] valid, input logic [31:0] data, input bit ready);
        bit finish;
        bit xfer;
        bit canIssue;
        int lane;
        mDone = 1'b0;
        case (mPhase)
            P_IDLE: begin
                if (st) begin
                    mPhase    = P_COLLECT;
                    mNextAddr = int'(base);
                    mTarget   = int'(num);
                    mWritten  = 0;
                    mOvf      = 1'b0;
                    mPtr      = 0;
                    mBusy     = 1'b1;
                    for (int k = 0; k < 4; k++) mFull[k] = 1'b0;
                end
            end
            P_COLLECT: begin
                finish   = (mWritten == mTarget) && !mReq;
                xfer     = mReq && ready;
                canIssue = (!mReq || ready) && ((mWritten + (mReq ? 1 : 0)) < mTarget);
                lane     = -1;
                if (canIssue) begin
                    for (int off = 0; off < 4; off++) begin
                        if (lane < 0 && mFull[(mPtr + off) % 4]) lane = (mPtr + off) % 4;
                    end
                end
                if (xfer) mWritten++;
                if (lane >= 0) begin
                    mReqData    = mLane[lane];
                    mReqAddr    = 10'(mNextAddr);
                    mNextAddr   = (mNextAddr + 1) % 1024;
                    mFull[lane] = 1'b0;
                    mPtr        = (lane + 1) % 4;
                    mReq        = 1'b1;
                end else if (xfer) begin
                    mReq = 1'b0;
                end
                for (int k = 0; k < 4; k++) begin
                    if (valid[k]) begin
                        if (mFull[k]) begin
                            mOvf = 1'b1;
                        end else begin
                            mLane[k] = data[k*8 +: 8];
                            mFull[k] = 1'b1;
                        end
                    end
                end
                if (finish) begin
                    mPhase = P_DONE;
                    mDone  = 1'b1;
                    mBusy  = 1'b0;
                    mJobs++;
                end
            end
            default: begin
                mPhase = P_IDLE;
                for (int k = 0; k < 4; k++) mFull[k] = 1'b0;
            end
        endcase
    endtask

    task automatic idleInputs();
        i_start       = 1'b0;
        i_base_addr   = '0;
        i_num_results = '0;
        i_mpu_data    = '0;
        i_mpu_valid   = '0;
        i_wr_ready    = 1'b0;
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Outputs after a reset with clean inputs.
    task automatic test_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge i_clk);
        #1;
        checkCount++;
        if (o_wr_en !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_wr_en got %b want 0", o_wr_en); end
        checkCount++;
        if (o_busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
        checkCount++;
        if (o_done !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_done got %b want 0", o_done); end
        checkCount++;
        if (o_overflow !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_overflow got %b want 0", o_overflow); end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // All four lanes in one cycle drain back to back in lane order.
    task automatic test_burst();
        logic [9:0] wAddr[$];
        logic [7:0] wData[$];
        int         wCyc[$];
        int         doneCnt = 0;
        int         doneCyc = -1;
        for (int it = 0; it < 30; it++) begin
            @(negedge i_clk);
            i_start       = (it == 0);
            i_base_addr   = 10'h010;
            i_num_results = 11'd4;
            i_wr_ready    = 1'b1;
            i_mpu_valid   = (it == 1) ? 4'hF : 4'h0;
            i_mpu_data    = 32'hA3A2A1A0;
            @(posedge i_clk);
            #1;
            if (it == 0) begin
                checkCount++;
                if (o_busy !== 1'b1) begin errorCount++; $display("[TB] FAIL burst_busy got %b want 1", o_busy); end
            end
            if (o_wr_en === 1'b1) begin
                wAddr.push_back(o_wr_addr);
                wData.push_back(o_wr_data);
                wCyc.push_back(it);
            end
            if (o_done === 1'b1) begin
                doneCnt++;
                doneCyc = it;
            end
        end
        checkCount++;
        if (wAddr.size() != 4) begin errorCount++; $display("[TB] FAIL burst_count got %0d want 4", wAddr.size()); end
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (i >= wAddr.size()) begin
                errorCount++; $display("[TB] FAIL burst_write%0d got none want %h/%h", i, 10'h010 + i, 8'hA0 + i);
            end else if (wAddr[i] !== 10'(10'h010 + i) || wData[i] !== 8'(8'hA0 + i) || wCyc[i] != wCyc[0] + i) begin
                errorCount++;
                $display("[TB] FAIL burst_write%0d got %h/%h@%0d want %h/%h@%0d", i, wAddr[i], wData[i], wCyc[i],
                         10'h010 + i, 8'hA0 + i, wCyc[0] + i);
            end
        end
        checkCount++;
        if (doneCnt != 1) begin errorCount++; $display("[TB] FAIL burst_done_count got %0d want 1", doneCnt); end
        checkCount++;
        if (wCyc.size() > 0 && doneCyc <= wCyc[wCyc.size()-1]) begin
            errorCount++; $display("[TB] FAIL burst_done_order got %0d want after %0d", doneCyc, wCyc[wCyc.size()-1]);
        end
        checkCount++;
        if (o_overflow !== 1'b0) begin errorCount++; $display("[TB] FAIL burst_overflow got %b want 0", o_overflow); end
    endtask

    // Write address wraps from the top of the buffer to zero.
    task automatic test_addr_wrap();
        logic [9:0] wAddr[$];
        logic [7:0] wData[$];
        logic [9:0] expAddr[3];
        int         doneCnt = 0;
        expAddr[0] = 10'h3FE;
        expAddr[1] = 10'h3FF;
        expAddr[2] = 10'h000;
        for (int it = 0; it < 30; it++) begin
            @(negedge i_clk);
            i_start       = (it == 0);
            i_base_addr   = 10'h3FE;
            i_num_results = 11'd3;
            i_wr_ready    = 1'b1;
            i_mpu_valid   = (it == 1 || it == 5 || it == 9) ? 4'b0100 : 4'b0000;
            i_mpu_data    = {8'h00, 8'(8'h30 + it / 4), 16'h0000};
            @(posedge i_clk);
            #1;
            if (o_wr_en === 1'b1) begin
                wAddr.push_back(o_wr_addr);
                wData.push_back(o_wr_data);
            end
            if (o_done === 1'b1) doneCnt++;
        end
        checkCount++;
        if (wAddr.size() != 3) begin errorCount++; $display("[TB] FAIL wrap_count got %0d want 3", wAddr.size()); end
        for (int i = 0; i < 3; i++) begin
            checkCount++;
            if (i >= wAddr.size()) begin
                errorCount++; $display("[TB] FAIL wrap_write%0d got none want %h", i, expAddr[i]);
            end else if (wAddr[i] !== expAddr[i] || wData[i] !== 8'(8'h30 + i)) begin
                errorCount++;
                $display("[TB] FAIL wrap_write%0d got %h/%h want %h/%h", i, wAddr[i], wData[i], expAddr[i], 8'h30 + i);
            end
        end
        checkCount++;
        if (o_overflow !== 1'b0) begin errorCount++; $display("[TB] FAIL wrap_overflow got %b want 0", o_overflow); end
        checkCount++;
        if (doneCnt != 1) begin errorCount++; $display("[TB] FAIL wrap_done_count got %0d want 1", doneCnt); end
    endtask

    // A stalled request holds address and data until the buffer accepts it.
    task automatic test_backpressure();
        int doneCnt = 0;
        int doneCyc = -1;
        for (int it = 0; it < 16; it++) begin
            @(negedge i_clk);
            i_start       = (it == 0);
            i_base_addr   = 10'h100;
            i_num_results = 11'd1;
            i_wr_ready    = (it >= 10);
            i_mpu_valid   = (it == 1) ? 4'b0001 : 4'b0000;
            i_mpu_data    = 32'h0000005A;
            @(posedge i_clk);
            #1;
            if (it == 1) begin
                checkCount++;
                if (o_wr_en !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_early_wr_en got %b want 0", o_wr_en); end
            end
            if (it == 2) begin
                checkCount++;
                if (o_wr_en !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_latency_wr_en got %b want 1", o_wr_en); end
            end
            if (it >= 3 && it <= 7) begin
                checkCount++;
                if (o_wr_en !== 1'b1 || o_wr_addr !== 10'h100 || o_wr_data !== 8'h5A) begin
                    errorCount++;
                    $display("[TB] FAIL bp_hold%0d got %b/%h/%h want 1/100/5a", it, o_wr_en, o_wr_addr, o_wr_data);
                end
                checkCount++;
                if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                    errorCount++; $display("[TB] FAIL bp_hold_state%0d got busy %b done %b want 1/0", it, o_busy, o_done);
                end
            end
            if (it == 10) begin
                checkCount++;
                if (o_wr_en !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_release_wr_en got %b want 0", o_wr_en); end
            end
            if (o_done === 1'b1) begin
                doneCnt++;
                doneCyc = it;
            end
        end
        checkCount++;
        if (doneCnt != 1 || doneCyc != 11) begin
            errorCount++; $display("[TB] FAIL bp_done got %0d@%0d want 1@11", doneCnt, doneCyc);
        end
    endtask

    // Third word on lane 1 arrives while the lane still holds the second.
    task automatic test_overrun();
        logic [9:0] wAddr[$];
        logic [7:0] wData[$];
        int         doneCnt = 0;
        for (int it = 0; it < 20; it++) begin
            @(negedge i_clk);
            i_start       = (it == 0);
            i_base_addr   = 10'h200;
            i_num_results = 11'd2;
            i_wr_ready    = (it >= 6);
            i_mpu_valid   = (it >= 1 && it <= 3) ? 4'b0010 : 4'b0000;
            i_mpu_data    = (it == 1) ? 32'h00001100 : (it == 2) ? 32'h00002200 : 32'h00003300;
            @(posedge i_clk);
            #1;
            if (o_wr_en === 1'b1 && (wAddr.size() == 0 || wAddr[wAddr.size()-1] !== o_wr_addr)) begin
                wAddr.push_back(o_wr_addr);
                wData.push_back(o_wr_data);
            end
            if (it == 2) begin
                checkCount++;
                if (o_overflow !== 1'b0) begin errorCount++; $display("[TB] FAIL ovr_refill_flag got %b want 0", o_overflow); end
            end
            if (it == 3) begin
                checkCount++;
                if (o_overflow !== 1'b1) begin errorCount++; $display("[TB] FAIL ovr_flag got %b want 1", o_overflow); end
            end
            if (o_done === 1'b1) doneCnt++;
        end
        checkCount++;
        if (wAddr.size() != 2) begin errorCount++; $display("[TB] FAIL ovr_count got %0d want 2", wAddr.size()); end
        checkCount++;
        if (wAddr.size() < 1 || wAddr[0] !== 10'h200 || wData[0] !== 8'h11) begin
            errorCount++; $display("[TB] FAIL ovr_first_write got %0d entries want 200/11", wAddr.size());
        end
        checkCount++;
        if (wAddr.size() < 2 || wAddr[1] !== 10'h201 || wData[1] !== 8'h22) begin
            errorCount++; $display("[TB] FAIL ovr_second_write got %0d entries want 201/22", wAddr.size());
        end
        checkCount++;
        if (o_overflow !== 1'b1) begin errorCount++; $display("[TB] FAIL ovr_sticky got %b want 1", o_overflow); end
        checkCount++;
        if (doneCnt != 1) begin errorCount++; $display("[TB] FAIL ovr_done_count got %0d want 1", doneCnt); end
    endtask

    // Reset aborts a running job; a following empty job still completes.
    task automatic test_reset_midjob();
        int stray = 0;
        for (int it = 0; it < 16; it++) begin
            @(negedge i_clk);
            i_rst         = (it == 5);
            i_start       = (it == 0 || it == 11);
            i_base_addr   = 10'h000;
            i_num_results = (it == 11) ? 11'd0 : 11'd4;
            i_wr_ready    = 1'b1;
            i_mpu_valid   = (it == 1) ? 4'hF : 4'h0;
            i_mpu_data    = 32'h44332211;
            @(posedge i_clk);
            #1;
            if (it == 3) begin
                checkCount++;
                if (o_wr_en !== 1'b1 || o_wr_addr !== 10'h001) begin
                    errorCount++; $display("[TB] FAIL rst_second_write got %b/%h want 1/001", o_wr_en, o_wr_addr);
                end
            end
            if (it == 5) begin
                checkCount++;
                if ({o_wr_en, o_busy, o_done, o_overflow} !== 4'b0000) begin
                    errorCount++;
                    $display("[TB] FAIL rst_abort got en/busy/done/ovf %b%b%b%b want 0000", o_wr_en, o_busy, o_done, o_overflow);
                end
            end
            if (it >= 6 && (o_wr_en !== 1'b0 || (it <= 10 && (o_done !== 1'b0 || o_busy !== 1'b0)))) stray++;
            if (it == 11) begin
                checkCount++;
                if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                    errorCount++; $display("[TB] FAIL empty_collect got busy %b done %b want 1/0", o_busy, o_done);
                end
            end
            if (it == 12) begin
                checkCount++;
                if (o_done !== 1'b1 || o_busy !== 1'b0) begin
                    errorCount++; $display("[TB] FAIL empty_done got done %b busy %b want 1/0", o_done, o_busy);
                end
            end
            if (it == 13) begin
                checkCount++;
                if (o_done !== 1'b0) begin errorCount++; $display("[TB] FAIL empty_done_pulse got %b want 0", o_done); end
            end
        end
        checkCount++;
        if (stray != 0) begin errorCount++; $display("[TB] FAIL rst_quiet got %0d stray cycles want 0", stray); end
    endtask

    // Random lanes, backpressure and job parameters against the model.
    task automatic test_random();
        bit          st;
        logic [9:0]  base;
        logic [10:0] num;
        logic [3:0]  valid;
        logic [31:0] data;
        bit          ready;
        int          dutDone = 0;
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge i_clk);
            st    = ($urandom_range(0, 3) == 0);
            base  = 10'($urandom_range(0, 1023));
            num   = 11'($urandom_range(0, 10));
            data  = $urandom;
            ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) valid[k] = ($urandom_range(0, 9) < 4);
            i_start       = st;
            i_base_addr   = base;
            i_num_results = num;
            i_mpu_valid   = valid;
            i_mpu_data    = data;
            i_wr_ready    = ready;
            @(posedge i_clk);
            modelStep(st, base, num, valid, data, ready);
            #1;
            if (o_done === 1'b1) dutDone++;
            checkCount++;
            if (o_wr_en !== mReq) begin
                errorCount++; $display("[TB] FAIL rand_wr_en cyc %0d got %b want %b", cyc, o_wr_en, mReq);
            end else if (mReq) begin
                checkCount++;
                if (o_wr_addr !== mReqAddr || o_wr_data !== mReqData) begin
                    errorCount++;
                    $display("[TB] FAIL rand_write cyc %0d got %h/%h want %h/%h", cyc, o_wr_addr, o_wr_data, mReqAddr, mReqData);
                end
            end
            checkCount++;
            if (o_busy !== mBusy || o_done !== mDone || o_overflow !== mOvf) begin
                errorCount++;
                $display("[TB] FAIL rand_status cyc %0d got busy/done/ovf %b%b%b want %b%b%b", cyc,
                         o_busy, o_done, o_overflow, mBusy, mDone, mOvf);
            end
        end
        checkCount++;
        if (dutDone != mJobs) begin
            errorCount++; $display("[TB] FAIL rand_jobs got %0d want %0d", dutDone, mJobs);
        end
        $display("[TB] random run completed %0d jobs", mJobs);
    endtask

    initial begin
        i_rst = 1'b1;
        idleInputs();
        modelReset();
        test_reset();
        test_burst();
        test_addr_wrap();
        test_backpressure();
        test_overrun();
        test_reset_midjob();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
